// File: rtl/uproc_pkg.sv
// uproc_pkg: shared opcode/register codes, NOP word and program-memory state enum.
package uproc_pkg;
    localparam logic [3:0] OPCODE_NOP = 4'h0;
    localparam logic [3:0] OPCODE_ADD = 4'h1;
    localparam logic [3:0] OPCODE_SUB = 4'h2;
    localparam logic [3:0] OPCODE_LD  = 4'h3;
    localparam logic [3:0] OPCODE_ST  = 4'h4;
    localparam logic [3:0] OPCODE_JMP = 4'h5;
    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;
    localparam logic [5:0] NOP_WORD = {OPCODE_NOP, 2'b00};
    typedef enum logic {PM_LOAD, PM_RUN} pmem_state_t;
endpackage

// File: rtl/pmem_array.sv
// pmem_array: single-write / single-read synchronous RAM with registered read port.
module pmem_array #(
    parameter int W      = 6,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable: sequentially loaded program memory with registered, count-gated fetch port.
// Optional even-parity storage and checking when PMEM_PARITY_EN is defined.
module prog_mem_loadable
    import uproc_pkg::*;
#(
    parameter int INSTR_W = 6,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               ld_err,
    output logic [ADDR_W:0]    ld_count,
    output logic               run,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               fetch_perr,
    input  logic               ld_par_flip
);
`ifdef PMEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif
    localparam logic [INSTR_W-1:0] NOP = {OPCODE_NOP, {(INSTR_W-4){1'b0}}};

    pmem_state_t state_q, state_d;
    logic [MEM_W-1:0] wdata, rdata;
    logic full, we, in_range, fetch_go, hit_q;

    assign ld_ready = state_q == PM_LOAD;
    assign run      = state_q == PM_RUN;
    assign full     = ld_count == (ADDR_W+1)'(DEPTH);
    assign we       = ld_ready & ld_valid & ~full;
    assign in_range = {1'b0, fetch_addr} < ld_count;
    assign fetch_go = run & fetch_req;

    always_comb begin
        state_d = state_q;
        state_d = (ld_ready & ld_valid & ld_last) ? PM_RUN :
                  (run & ld_start)                ? PM_LOAD : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PM_LOAD;
            ld_count    <= '0;
            ld_err      <= 1'b0;
            fetch_valid <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_valid <= fetch_go;
            if (fetch_go) hit_q <= in_range;
            if (run & ld_start) begin
                ld_count <= '0;
                ld_err   <= 1'b0;
            end else if (ld_ready & ld_valid) begin
                if (full) ld_err <= 1'b1;
                else ld_count <= ld_count + 1'b1;
            end
        end
    end

    // Out-of-range fetches skip the RAM read; hit_q substitutes NOP instead.
    pmem_array #(.W(MEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (ld_count[ADDR_W-1:0]),
        .wdata (wdata),
        .re    (fetch_go & in_range),
        .raddr (fetch_addr),
        .rdata (rdata)
    );

    assign fetch_instr = hit_q ? rdata[INSTR_W-1:0] : NOP;

`ifdef PMEM_PARITY_EN
    assign wdata      = {^ld_data ^ ld_par_flip, ld_data};
    assign fetch_perr = fetch_valid & hit_q & (^rdata);
`else
    logic unused_par;
    assign unused_par = ld_par_flip;
    assign wdata      = ld_data;
    assign fetch_perr = 1'b0;
`endif
endmodule

// File: tb/tb_prog_mem_loadable.sv
// tb_prog_mem_loadable: directed self-checking bench for prog_mem_loadable.
// Parity checks run only when PMEM_PARITY_EN is defined.
module tb_prog_mem_loadable;
    logic       clk = 1'b0, rst = 1'b1;
    logic       ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, ld_par_flip = 1'b0;
    logic [5:0] ld_data = '0;
    logic       ld_ready, ld_err, run;
    logic [5:0] ld_count;
    logic       fetch_req = 1'b0;
    logic [4:0] fetch_addr = '0;
    logic       fetch_valid, fetch_perr;
    logic [5:0] fetch_instr;
    int n_cmp = 0, n_bad = 0;

    // ADD R1, SUB R1, ST R3 as {opcode, reg}
    localparam logic [5:0] W_ADD = 6'h05, W_SUB = 6'h09, W_ST = 6'h13, W_NOP = 6'h00;

    prog_mem_loadable dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_err(ld_err), .ld_count(ld_count), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_perr(fetch_perr), .ld_par_flip(ld_par_flip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] d, input logic last, input logic flip);
        ld_valid = 1'b1; ld_data = d; ld_last = last; ld_par_flip = flip;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0; ld_par_flip = 1'b0;
    endtask

    task automatic fetch(input logic [4:0] a);
        fetch_req = 1'b1; fetch_addr = a;
        tick();
        fetch_req = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", ld_ready, 1);
        chk("rst_run", run, 0);
        chk("rst_count", ld_count, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_instr", fetch_instr, W_NOP);
        chk("rst_perr", fetch_perr, 0);
        rst = 1'b0;
        tick();

        load(W_ADD, 1'b0, 1'b0);
        chk("t1_count1", ld_count, 1);
        load(W_SUB, 1'b0, 1'b0);
        chk("t1_run_early", run, 0);
        load(W_ST, 1'b1, 1'b0);
        chk("t1_count", ld_count, 3);
        chk("t1_run", run, 1);

        fetch_req = 1'b1; fetch_addr = 5'd0;
        tick();
        chk("t2_v0", fetch_valid, 1);
        chk("t2_i0", fetch_instr, W_ADD);
        chk("t2_p0", fetch_perr, 0);
        fetch_addr = 5'd1;
        tick();
        chk("t2_v1", fetch_valid, 1);
        chk("t2_i1", fetch_instr, W_SUB);
        fetch_addr = 5'd2;
        tick();
        chk("t2_v2", fetch_valid, 1);
        chk("t2_i2", fetch_instr, W_ST);
        fetch_addr = 5'd3;
        tick();
        chk("t2_v3", fetch_valid, 1);
        chk("t2_i3", fetch_instr, W_NOP);
        fetch_addr = 5'd2;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("t2_idle_valid", fetch_valid, 0);
        chk("t2_idle_hold", fetch_instr, W_ST);

        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("t3_load_state", ld_ready, 1);
        for (int i = 0; i <= 32; i++) begin
            load(6'(i * 7 + 3), i == 32, 1'b0);
            if (i == 31) begin
                chk("t3_full_count", ld_count, 32);
                chk("t3_full_err", ld_err, 0);
            end
        end
        chk("t3_err", ld_err, 1);
        chk("t3_count", ld_count, 32);
        chk("t3_run", run, 1);
        fetch(5'd31);
        chk("t3_last_word", fetch_instr, 6'd28);
        fetch(5'd0);
        chk("t3_first_word", fetch_instr, 6'd3);

        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("t4_err_clr", ld_err, 0);
        chk("t4_count_clr", ld_count, 0);
        load(W_ADD, 1'b0, 1'b0);
        load(W_SUB, 1'b1, 1'b0);
        chk("t4_run", run, 1);
        fetch_req = 1'b1; fetch_addr = 5'd1; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("t4_valid", fetch_valid, 1);
        chk("t4_instr", fetch_instr, W_SUB);
        chk("t4_run_off", run, 0);
        chk("t4_count", ld_count, 0);
        fetch_addr = 5'd0;
        tick();
        fetch_req = 1'b0;
        chk("t4_load_fetch_valid", fetch_valid, 0);
        chk("t4_load_fetch_hold", fetch_instr, W_SUB);

        load(W_ADD, 1'b0, 1'b0);
        load(W_SUB, 1'b0, 1'b0);
        chk("t5_count2", ld_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_count", ld_count, 0);
        chk("t5_rst_ready", ld_ready, 1);
        chk("t5_rst_run", run, 0);
        rst = 1'b0;
        load(W_ADD, 1'b1, 1'b0);
        chk("t5_reload_count", ld_count, 1);
        fetch(5'd1);
        chk("t5_stale_valid", fetch_valid, 1);
        chk("t5_stale_nop", fetch_instr, W_NOP);
        fetch_req = 1'b1; fetch_addr = 5'd0;
        tick();
        chk("t5_pre_rst_instr", fetch_instr, W_ADD);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_valid", fetch_valid, 0);
        chk("t5_async_instr", fetch_instr, W_NOP);
        fetch_req = 1'b0;
        rst = 1'b0;
        tick();

`ifdef PMEM_PARITY_EN
        load(W_ADD, 1'b0, 1'b0);
        load(W_SUB, 1'b0, 1'b0);
        load(W_ST, 1'b1, 1'b1);
        fetch(5'd2);
        chk("t6_perr_flip", fetch_perr, 1);
        chk("t6_instr_flip", fetch_instr, W_ST);
        fetch(5'd1);
        chk("t6_perr_ok", fetch_perr, 0);
        fetch(5'd5);
        chk("t6_perr_nop", fetch_perr, 0);
        chk("t6_instr_nop", fetch_instr, W_NOP);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
